// File: rtl/rand_range_arbiter_if.sv
// Request/acknowledge bundle between the requesters and rand_range_arbiter.
// Carries served_cnt/reject_cnt only when RAND_ARB_STATS_EN is defined.
interface rand_range_arbiter_if #(
   parameter int unsigned NREQ = 4
);
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] ack;
   logic            err;
   logic [7:0]      rand_out;
   logic            busy;
`ifdef RAND_ARB_STATS_EN
   logic [15:0]     served_cnt;
   logic [15:0]     reject_cnt;

   modport master (output req, input ack, err, rand_out, busy, served_cnt, reject_cnt);
   modport slave  (input req, output ack, err, rand_out, busy, served_cnt, reject_cnt);
`else
   modport master (output req, input ack, err, rand_out, busy);
   modport slave  (input req, output ack, err, rand_out, busy);
`endif
endinterface

// File: rtl/rand_range_arbiter.sv
// Round-robin arbiter handing each requester one in-window sample from a shared 18-bit LFSR.
// Optional RAND_ARB_STATS_EN adds saturating served/reject counters.
module rand_range_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter logic [7:0]  LOW     = 8'd90,
   parameter logic [7:0]  HIGH    = 8'd128,
   parameter logic [17:0] SEED    = 18'd3,
   parameter int unsigned MAX_TRY = 64
) (
   input logic                 clk,
   input logic                 rst,
   rand_range_arbiter_if.slave bus
);
   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEARCH,
      S_DELIVER
   } state_t;

   state_t          r_state;
   logic [17:0]     r_lfsr;
   logic [PW-1:0]   r_ptr;
   logic [PW-1:0]   r_g;
   logic [9:0]      r_try;
   logic [NREQ-1:0] r_ack;
   logic            r_err;
   logic [7:0]      r_rand;
   logic            r_busy;

   logic [17:0]     w_lfsr_next;
   logic [7:0]      w_sample;
   logic [8:0]      w_lo_diff;
   logic [8:0]      w_hi_diff;
   logic            w_in_range;
   logic            w_req_g;
   logic [NREQ-1:0] w_g_onehot;
   logic            w_gnt_any;
   logic [PW-1:0]   w_gnt_idx;
   int unsigned     w_scan;

   assign w_lfsr_next = {r_lfsr[16:0], ~(r_lfsr[17] ^ r_lfsr[10]) ^ (&r_lfsr[16:0])};
   assign w_sample    = r_lfsr[7:0];

   // Window test by 9-bit subtraction borrow, so LOW=0 or HIGH=255 stay well-formed.
   assign w_lo_diff   = {1'b0, w_sample} - {1'b0, LOW};
   assign w_hi_diff   = {1'b0, HIGH} - {1'b0, w_sample};
   assign w_in_range  = ~w_lo_diff[8] & ~w_hi_diff[8];

   assign w_req_g     = bus.req[r_g];
   assign w_g_onehot  = {{(NREQ-1){1'b0}}, 1'b1} << r_g;

   always_comb begin
      w_gnt_any = 1'b0;
      w_gnt_idx = '0;
      w_scan    = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         w_scan = 32'(r_ptr) + i;
         if (w_scan >= NREQ) w_scan = w_scan - NREQ;
         if (!w_gnt_any && bus.req[PW'(w_scan)]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = PW'(w_scan);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_lfsr  <= SEED;
         r_ptr   <= '0;
         r_g     <= '0;
         r_try   <= '0;
         r_ack   <= '0;
         r_err   <= 1'b0;
         r_rand  <= '0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_gnt_any) begin
                  r_g     <= w_gnt_idx;
                  r_try   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_SEARCH;
               end
            end
            S_SEARCH: begin
               r_lfsr <= w_lfsr_next;
               if (!w_req_g) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else if (w_in_range) begin
                  r_rand  <= w_sample;
                  r_err   <= 1'b0;
                  r_ack   <= w_g_onehot;
                  r_state <= S_DELIVER;
               end else if (r_try == 10'(MAX_TRY - 1)) begin
                  r_rand  <= '0;
                  r_err   <= 1'b1;
                  r_ack   <= w_g_onehot;
                  r_state <= S_DELIVER;
               end else begin
                  r_try <= r_try + 10'd1;
               end
            end
            S_DELIVER: begin
               r_ack   <= '0;
               r_err   <= 1'b0;
               r_busy  <= 1'b0;
               r_ptr   <= (r_g == PW'(NREQ - 1)) ? '0 : r_g + 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.ack      = r_ack;
   assign bus.err      = r_err;
   assign bus.rand_out = r_rand;
   assign bus.busy     = r_busy;

`ifdef RAND_ARB_STATS_EN
   logic [15:0] r_served_cnt;
   logic [15:0] r_reject_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_served_cnt <= '0;
         r_reject_cnt <= '0;
      end else begin
         if (r_state == S_DELIVER && !r_err && r_served_cnt != '1)
            r_served_cnt <= r_served_cnt + 16'd1;
         if (r_state == S_SEARCH && w_req_g && !w_in_range && r_reject_cnt != '1)
            r_reject_cnt <= r_reject_cnt + 16'd1;
      end
   end

   assign bus.served_cnt = r_served_cnt;
   assign bus.reject_cnt = r_reject_cnt;
`endif
endmodule

// File: tb/tb_rand_range_arbiter.sv
// Directed bench for rand_range_arbiter: default, full-window and MAX_TRY=4 instances.
module tb_rand_range_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass = 0;
   int   n_fail = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   rand_range_arbiter_if #(.NREQ(4)) if_def ();
   rand_range_arbiter_if #(.NREQ(4)) if_wide ();
   rand_range_arbiter_if #(.NREQ(4)) if_try ();

   rand_range_arbiter #(.NREQ(4)) u_def (
      .clk (clk),
      .rst (rst),
      .bus (if_def)
   );

   rand_range_arbiter #(.NREQ(4), .LOW(8'd0), .HIGH(8'd255)) u_wide (
      .clk (clk),
      .rst (rst),
      .bus (if_wide)
   );

   rand_range_arbiter #(.NREQ(4), .MAX_TRY(4)) u_try (
      .clk (clk),
      .rst (rst),
      .bus (if_try)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      if_def.req  = '0;
      if_wide.req = '0;
      if_try.req  = '0;
      cyc(1);
   endtask

   initial begin
      logic [7:0] exp_wide [4];
      exp_wide = '{8'd3, 8'd7, 8'd15, 8'd31};
      if_def.req  = '0;
      if_wide.req = '0;
      if_try.req  = '0;

      // Reset state
      #3;
      chk("rst_ack", 32'(if_def.ack), 32'd0);
      chk("rst_err", 32'(if_def.err), 32'd0);
      chk("rst_busy", 32'(if_def.busy), 32'd0);
      chk("rst_rand", 32'(if_def.rand_out), 32'd0);

      // Default window, single requester: checks 3,7,15,31,63,127 -> ack in cycle 7
      @(negedge clk);
      rst = 1'b0;
      if_def.req = 4'b0001;
      cyc(1);
      chk("t1_c1_busy", 32'(if_def.busy), 32'd1);
      chk("t1_c1_ack", 32'(if_def.ack), 32'd0);
      cyc(5);
      chk("t1_c6_ack", 32'(if_def.ack), 32'd0);
      cyc(1);
      chk("t1_c7_ack", 32'(if_def.ack), 32'b0001);
      chk("t1_c7_rand", 32'(if_def.rand_out), 32'd127);
      chk("t1_c7_err", 32'(if_def.err), 32'd0);
      if_def.req = 4'b0000;
      cyc(1);
      chk("t1_c8_ack", 32'(if_def.ack), 32'd0);
      chk("t1_c8_busy", 32'(if_def.busy), 32'd0);
`ifdef RAND_ARB_STATS_EN
      chk("t1_served", 32'(if_def.served_cnt), 32'd1);
      chk("t1_reject", 32'(if_def.reject_cnt), 32'd5);
`endif

      // Full window, all requesting: round robin 0..3, acks in cycles 2,5,8,11
      apply_reset();
      rst = 1'b0;
      if_wide.req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         cyc((k == 0) ? 2 : 3);
         chk($sformatf("t2_ack%0d", k), 32'(if_wide.ack), 32'd1 << k);
         chk($sformatf("t2_rand%0d", k), 32'(if_wide.rand_out), 32'(exp_wide[k]));
      end
      cyc(1);
      chk("t2_c12_ack", 32'(if_wide.ack), 32'd0);
      if_wide.req = 4'b0000;

      // MAX_TRY=4: error ack in cycle 5, then pointer moves to requester 3
      apply_reset();
      rst = 1'b0;
      if_try.req = 4'b0100;
      cyc(4);
      chk("t3_c4_ack", 32'(if_try.ack), 32'd0);
      chk("t3_c4_busy", 32'(if_try.busy), 32'd1);
      cyc(1);
      chk("t3_c5_ack", 32'(if_try.ack), 32'b0100);
      chk("t3_c5_err", 32'(if_try.err), 32'd1);
      chk("t3_c5_rand", 32'(if_try.rand_out), 32'd0);
      if_try.req = 4'b1111;
      cyc(1);
      chk("t3_c6_err", 32'(if_try.err), 32'd0);
      chk("t3_c6_ack", 32'(if_try.ack), 32'd0);
      cyc(3);
      chk("t3_c9_ack", 32'(if_try.ack), 32'b1000);
      chk("t3_c9_err", 32'(if_try.err), 32'd0);
      chk("t3_c9_rand", 32'(if_try.rand_out), 32'd127);
      if_try.req = 4'b0000;

      // Abandon: req[0] drops in cycle 3, req[1] granted in cycle 4, first check sees 31
      apply_reset();
      rst = 1'b0;
      if_def.req = 4'b0001;
      cyc(3);
      chk("t4_c3_busy", 32'(if_def.busy), 32'd1);
      if_def.req = 4'b0010;
      cyc(1);
      chk("t4_c4_busy", 32'(if_def.busy), 32'd0);
      chk("t4_c4_ack", 32'(if_def.ack), 32'd0);
      cyc(3);
      chk("t4_c7_ack", 32'(if_def.ack), 32'd0);
      cyc(1);
      chk("t4_c8_ack", 32'(if_def.ack), 32'b0010);
      chk("t4_c8_rand", 32'(if_def.rand_out), 32'd127);
      if_def.req = 4'b0000;

      // Asynchronous reset mid-SEARCH, then the sequence restarts from the seed
      apply_reset();
      rst = 1'b0;
      if_def.req = 4'b0001;
      cyc(3);
      chk("t5_pre_busy", 32'(if_def.busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_busy", 32'(if_def.busy), 32'd0);
      chk("t5_rst_ack", 32'(if_def.ack), 32'd0);
      chk("t5_rst_err", 32'(if_def.err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      cyc(6);
      chk("t5_c6_ack", 32'(if_def.ack), 32'd0);
      cyc(1);
      chk("t5_c7_ack", 32'(if_def.ack), 32'b0001);
      chk("t5_c7_rand", 32'(if_def.rand_out), 32'd127);
      if_def.req = 4'b0000;
      cyc(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
